pipe_mac_stage: RTL and testbench

//  Pipelined signed multiply-accumulate stage; the producer that feeds the WIDTH-bit pipeline register stage.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_mac_sat.sv | 59 +++++
 rtl/pipe_mac_stage.sv | 114 +++++++++++
 tb/tb_pipe_mac_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the pipeline MAC stage and its neighbours.
//   Provides the default operand/accumulator widths, the default result
//   scaling shift, and signed typedefs at those default widths.
//   No ports (package).
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH     = 16;
  localparam int unsigned PIPE_ACC_WIDTH = 40;
  localparam int unsigned PIPE_SHIFT     = 15;

  typedef logic signed [PIPE_WIDTH-1:0]     operand_t;
  typedef logic signed [2*PIPE_WIDTH-1:0]   product_t;
  typedef logic signed [PIPE_ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/pipe_mac_sat.sv
// pipe_mac_sat
//   Combinational result formatter for the MAC stage: arithmetic right shift
//   of the accumulated sum by SHIFT, then reduction to WIDTH bits.
//   Configuration macro MAC_SAT_EN:
//     defined   - out-of-range values clamp to the nearest WIDTH-bit bound
//                 and ovf flags the clamp
//     undefined - plain truncation to the low WIDTH bits, ovf tied to 0
// Ports
//   sum  in   ACC_WIDTH  signed accumulated sum
//   res  out  WIDTH      formatted result
//   ovf  out  1          result did not fit in WIDTH bits (saturating build only)
module pipe_mac_sat
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = PIPE_WIDTH,
  parameter int unsigned ACC_WIDTH = PIPE_ACC_WIDTH,
  parameter int unsigned SHIFT     = PIPE_SHIFT
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic        [WIDTH-1:0]     res,
  output logic                        ovf
);

  logic signed [ACC_WIDTH-1:0] shifted_s;

  assign shifted_s = sum >>> SHIFT;

`ifdef MAC_SAT_EN
  // Bounds of a signed WIDTH-bit value, sign-extended to the accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] MAX_V =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V =
    {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // Clamp the shifted sum into the signed WIDTH-bit range.
  always_comb begin
    res = shifted_s[WIDTH-1:0];
    ovf = 1'b0;
    if (shifted_s > MAX_V) begin
      res = {1'b0, {(WIDTH-1){1'b1}}};
      ovf = 1'b1;
    end else if (shifted_s < MIN_V) begin
      res = {1'b1, {(WIDTH-1){1'b0}}};
      ovf = 1'b1;
    end else begin
      res = shifted_s[WIDTH-1:0];
      ovf = 1'b0;
    end
  end
`else
  // High bits are intentionally discarded by the wrapping result.
  logic unused_high_s;

  assign unused_high_s = ^shifted_s[ACC_WIDTH-1:WIDTH];
  assign res           = shifted_s[WIDTH-1:0];
  assign ovf           = 1'b0;
`endif

endmodule

// File: rtl/pipe_mac_stage.sv
// pipe_mac_stage
//   Pipelined signed multiply-accumulate stage. Operand pairs arrive under a
//   valid/ready handshake and are summed over a frame closed by InLast; one
//   scaled WIDTH-bit result per frame is held in a registered output until
//   the consumer takes it. Stage 1 registers the product, stage 2 adds it to
//   the accumulator and, on the last beat, publishes the formatted result.
//   The whole pipe advances on a single enable, so a pending result that is
//   not taken freezes both stages and the accumulator.
//   Result formatting (wrap or saturate) is selected by macro MAC_SAT_EN
//   inside pipe_mac_sat.
// Ports
//   Clk       in   1      clock, rising edge
//   Rst       in   1      synchronous reset, active-high
//   InValid   in   1      operand beat valid
//   InReady   out  1      stage can accept a beat (combinational)
//   InA       in   WIDTH  signed operand A
//   InB       in   WIDTH  signed operand B
//   InLast    in   1      beat is the last of its frame
//   OutValid  out  1      Out holds a result
//   OutReady  in   1      consumer takes Out this cycle
//   Out       out  WIDTH  frame result
//   Ovf       out  1      result overflowed WIDTH (valid with OutValid)
module pipe_mac_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = PIPE_WIDTH,
  parameter int unsigned ACC_WIDTH = PIPE_ACC_WIDTH,
  parameter int unsigned SHIFT     = PIPE_SHIFT
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic signed [WIDTH-1:0] InA,
  input  logic signed [WIDTH-1:0] InB,
  input  logic                    InLast,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic        [WIDTH-1:0] Out,
  output logic                    Ovf
);

  logic                          en_s;
  logic                          accept_s;
  logic signed [2*WIDTH-1:0]     prod_s;
  logic signed [ACC_WIDTH-1:0]   prod_ext_s;
  logic signed [ACC_WIDTH-1:0]   sum_s;
  logic        [WIDTH-1:0]       sat_res_s;
  logic                          sat_ovf_s;

  logic                          s1_vld_r;
  logic                          s1_last_r;
  logic signed [2*WIDTH-1:0]     s1_prod_r;
  logic signed [ACC_WIDTH-1:0]   acc_r;
  logic        [WIDTH-1:0]       out_r;
  logic                          ovf_r;
  logic                          out_valid_r;

  // The pipe moves whenever the output slot is empty or being emptied.
  assign en_s     = ~out_valid_r | OutReady;
  assign accept_s = InValid & en_s;
  assign InReady  = en_s;

  // Both operands are signed, so the product is a full signed 2*WIDTH result.
  assign prod_s     = InA * InB;
  assign prod_ext_s = ACC_WIDTH'(s1_prod_r);
  // Accumulator wraps at ACC_WIDTH bits by design; it is never saturated.
  assign sum_s      = acc_r + prod_ext_s;

  pipe_mac_sat #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT)
  ) u_sat (
    .sum (sum_s),
    .res (sat_res_s),
    .ovf (sat_ovf_s)
  );

  // Stage 1, stage 2/accumulator and output register, all gated by en_s.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_vld_r    <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_prod_r   <= '0;
      acc_r       <= '0;
      out_r       <= '0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (en_s) begin
      s1_vld_r  <= accept_s;
      s1_last_r <= InLast;
      s1_prod_r <= prod_s;
      if (s1_vld_r && s1_last_r) begin
        // Frame closes: publish the result (replacing any taken one) and
        // restart the accumulator for the next frame.
        acc_r       <= '0;
        out_r       <= sat_res_s;
        ovf_r       <= sat_ovf_s;
        out_valid_r <= 1'b1;
      end else if (s1_vld_r) begin
        acc_r       <= sum_s;
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign Out      = out_r;
  assign Ovf      = ovf_r;
  assign OutValid = out_valid_r;

endmodule

// File: tb/tb_pipe_mac_stage.sv
// tb_pipe_mac_stage
//   Directed bench for pipe_mac_stage. Two instances share the same input
//   stimulus: one built with SHIFT=0 and one with SHIFT=15, so each frame
//   exercises both the unscaled and the scaled result path. Expected values
//   are hand-computed; those that depend on MAC_SAT_EN are selected by the
//   same macro.
module tb_pipe_mac_stage;
  import pipe_pkg::*;

`ifdef MAC_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  logic     clk;
  logic     rst;
  logic     in_valid;
  logic     in_last;
  logic     out_ready;
  operand_t in_a;
  operand_t in_b;

  logic        in_ready0, out_valid0, ovf0;
  logic [15:0] out0;
  logic        in_ready15, out_valid15, ovf15;
  logic [15:0] out15;

  int checks = 0;
  int errors = 0;

  pipe_mac_stage #(.WIDTH(16), .ACC_WIDTH(40), .SHIFT(0)) dut0 (
    .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(in_ready0),
    .InA(in_a), .InB(in_b), .InLast(in_last), .OutValid(out_valid0),
    .OutReady(out_ready), .Out(out0), .Ovf(ovf0)
  );

  pipe_mac_stage #(.WIDTH(16), .ACC_WIDTH(40), .SHIFT(15)) dut15 (
    .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(in_ready15),
    .InA(in_a), .InB(in_b), .InLast(in_last), .OutValid(out_valid15),
    .OutReady(out_ready), .Out(out15), .Ovf(ovf15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_outvalid", {15'd0, out_valid0}, 16'd0);
    chk("rst_out",      out0,                16'd0);
    chk("rst_ovf",      {15'd0, ovf0},       16'd0);
    chk("rst_inready",  {15'd0, in_ready0},  16'd1);

    // Reset mid-frame, then a fresh frame: 2*3 + 4*5 = 26
    beat(16'd10, 16'd10, 1'b0);
    beat(16'd20, 16'd20, 1'b0);
    beat(16'd30, 16'd30, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outvalid", {15'd0, out_valid0}, 16'd0);
    chk("abort_inready",  {15'd0, in_ready0},  16'd1);
    beat(16'd2, 16'd3, 1'b0);
    beat(16'd4, 16'd5, 1'b1);
    chk("abort_lat1", {15'd0, out_valid0}, 16'd0);
    tick();
    chk("abort_valid",  {15'd0, out_valid0}, 16'd1);
    chk("abort_out0",   out0,  16'd26);
    chk("abort_out15",  out15, 16'd0);
    tick();
    chk("abort_drain", {15'd0, out_valid0}, 16'd0);

    // Basic frame: 1 + 4 + 9 = 14, two cycles after the last beat
    beat(16'd1, 16'd1, 1'b0);
    beat(16'd2, 16'd2, 1'b0);
    beat(16'd3, 16'd3, 1'b1);
    chk("basic_lat1", {15'd0, out_valid0}, 16'd0);
    tick();
    chk("basic_valid", {15'd0, out_valid0}, 16'd1);
    chk("basic_out",   out0, 16'd14);
    chk("basic_ovf",   {15'd0, ovf0}, 16'd0);
    tick();

    // Back-to-back single-beat frames: -21 then 25 on consecutive cycles
    in_valid = 1'b1; in_a = 16'hFFFD; in_b = 16'd7; in_last = 1'b1;
    tick();
    chk("b2b_ready1", {15'd0, in_ready0}, 16'd1);
    in_a = 16'd5; in_b = 16'd5;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_valid1", {15'd0, out_valid0}, 16'd1);
    chk("b2b_out1",   out0,  16'hFFEB);   // -21
    chk("b2b_out1_s", out15, 16'hFFFF);   // -21 >>> 15 = -1
    chk("b2b_ready2", {15'd0, in_ready0}, 16'd1);
    tick();
    chk("b2b_valid2", {15'd0, out_valid0}, 16'd1);
    chk("b2b_out2",   out0, 16'd25);
    tick();
    chk("b2b_drain",  {15'd0, out_valid0}, 16'd0);

    // Backpressure: result 7 pending, consumer stalls for 5 cycles
    out_ready = 1'b0;
    beat(16'd7, 16'd1, 1'b1);
    tick();
    chk("bp_valid", {15'd0, out_valid0}, 16'd1);
    in_valid = 1'b1; in_a = 16'd100; in_b = 16'd100; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_inready", {15'd0, in_ready0}, 16'd0);
      chk("bp_hold",    out0, 16'd7);
      tick();
    end
    chk("bp_hold_valid", {15'd0, out_valid0}, 16'd1);
    chk("bp_hold_out",   out0, 16'd7);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {15'd0, in_ready0}, 16'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_taken", {15'd0, out_valid0}, 16'd0);
    tick();
    chk("bp_next_valid", {15'd0, out_valid0}, 16'd1);
    chk("bp_next_out",   out0, 16'd10000);
    tick();
    chk("bp_no_dup", {15'd0, out_valid0}, 16'd0);

    // Overflow at SHIFT=0: 32767^2 + 1 = 0x3FFF0002
    beat(16'd32767, 16'd32767, 1'b0);
    beat(16'd1, 16'd1, 1'b1);
    tick();
    chk("ovf_out0",  out0, SAT ? 16'h7FFF : 16'h0002);
    chk("ovf_ovf0",  {15'd0, ovf0}, {15'd0, SAT});
    chk("ovf_out15", out15, 16'h7FFE);    // 0x3FFF0002 >>> 15
    chk("ovf_ovf15", {15'd0, ovf15}, 16'd0);
    tick();

    // Negative bound: -32768 * 32767 = -0x3FFF8000
    beat(16'h8000, 16'd32767, 1'b1);
    tick();
    chk("neg_out0",  out0, 16'h8000);
    chk("neg_ovf0",  {15'd0, ovf0}, {15'd0, SAT});
    chk("neg_out15", out15, 16'h8001);    // exactly -32767
    chk("neg_ovf15", {15'd0, ovf15}, 16'd0);
    tick();

    // SHIFT=15 scaling: 16384^2 = 2^28 -> 8192
    beat(16'd16384, 16'd16384, 1'b1);
    tick();
    chk("scale_out15", out15, 16'd8192);
    chk("scale_ovf15", {15'd0, ovf15}, 16'd0);
    chk("scale_out0",  out0, SAT ? 16'h7FFF : 16'h0000);
    tick();

    // (-32768)^2 = 2^30 -> 32768 after shift, out of range
    beat(16'h8000, 16'h8000, 1'b1);
    tick();
    chk("max_out15", out15, SAT ? 16'h7FFF : 16'h8000);
    chk("max_ovf15", {15'd0, ovf15}, {15'd0, SAT});
    chk("max_out0",  out0, SAT ? 16'h7FFF : 16'h0000);
    tick();
    chk("end_idle", {15'd0, out_valid0}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
